// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
//   Output reorder buffer for the streaming radix-2^2 FFT. Samples arrive one
//   per cycle in bit-reversed order and leave each frame in natural bin order
//   (0..N_POINTS-1). A ping-pong pair of banks lets one frame be written
//   while the previous one is read out.
//
// Ports
//   clk, rst        : clock / asynchronous active-high reset
//   en              : global enable; when low every register holds
//   in_val          : input sample valid (input side cannot be stalled)
//   in_re, in_im    : input sample, bit-reversed frame order
//   out_rdy         : downstream ready
//   out_val         : output sample valid
//   out_re, out_im  : output sample, natural order
//   out_last        : marks bin N_POINTS-1 of a frame
//   ovf             : sticky, a frame was dropped because both banks were full
// ---------------------------------------------------------------------------
module fft_bitrev_reorder #(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_val,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  input  logic                  out_rdy,
  output logic                  out_val,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic                  out_last,
  output logic                  ovf
);

  localparam int               LOG2N    = $clog2(N_POINTS);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
  } sample_t;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  // Two banks, combinational read.
  sample_t mem [2][N_POINTS];

  logic [1:0] full;
  logic [1:0] full_set;
  logic [1:0] full_clr;

  // -------------------------------------------------------------------------
  // Write side
  // -------------------------------------------------------------------------
  logic [LOG2N-1:0] wr_cnt;
  logic [LOG2N-1:0] wr_addr;
  logic             wr_bank;
  logic             drop;
  logic             wr_fire;
  logic             wr_first;
  logic             wr_wrap;
  logic             wr_drop;
  logic             wr_store;

  // Bit-reversed write address: natural index lands where the reader expects.
  for (genvar b = 0; b < LOG2N; b++) begin : g_bitrev
    assign wr_addr[b] = wr_cnt[LOG2N-1-b];
  end

  assign wr_fire  = en && in_val;
  assign wr_first = (wr_cnt == '0);
  assign wr_wrap  = (wr_cnt == LAST_IDX);
  // The drop decision is taken on sample 0 from the pre-edge full flag and
  // then carried by the drop register for the rest of the frame.
  assign wr_drop  = wr_first ? full[wr_bank] : drop;
  assign wr_store = wr_fire && !wr_drop;
  assign full_set = (wr_fire && wr_wrap && !wr_drop) ? (2'b01 << wr_bank) : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
      drop    <= 1'b0;
      ovf     <= 1'b0;
    end else if (wr_fire) begin
      // Counter keeps running through a dropped frame so alignment holds.
      wr_cnt <= wr_cnt + 1'b1;
      drop   <= wr_drop && !wr_wrap;
      if (wr_wrap) begin
        if (wr_drop) ovf     <= 1'b1;
        else         wr_bank <= ~wr_bank;
      end
    end
  end

  // Storage has no reset; contents are only read after a full frame lands.
  always_ff @(posedge clk) begin
    if (wr_store) mem[wr_bank][wr_addr] <= {in_re, in_im};
  end

  // -------------------------------------------------------------------------
  // Read side
  // -------------------------------------------------------------------------
  rd_state_t        state;
  rd_state_t        state_nxt;
  logic [LOG2N-1:0] rd_cnt;
  logic             rd_bank;
  logic             can_load;
  logic             load;
  logic             rd_wrap;
  sample_t          rd_word;

  assign rd_word  = mem[rd_bank][rd_cnt];
  assign can_load = !out_val || out_rdy;
  assign rd_wrap  = (rd_cnt == LAST_IDX);
  assign full_clr = (en && load && rd_wrap) ? (2'b01 << rd_bank) : 2'b00;

  // Bin 0 is loaded on the same edge that leaves IDLE, so it appears one
  // cycle after the frame completes. On the last bin the reader continues
  // straight into the other bank when that bank is already full.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_nxt = READ;
          load      = can_load;
        end
      end
      READ: begin
        load = can_load;
        if (load && rd_wrap) state_nxt = full[~rd_bank] ? READ : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     state <= IDLE;
    else if (en) state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
      out_val  <= 1'b0;
      out_re   <= '0;
      out_im   <= '0;
      out_last <= 1'b0;
    end else if (en) begin
      if (load) begin
        out_val  <= 1'b1;
        out_re   <= rd_word.re;
        out_im   <= rd_word.im;
        out_last <= rd_wrap;
        rd_cnt   <= rd_cnt + 1'b1;
        if (rd_wrap) rd_bank <= ~rd_bank;
      end else if (out_val && out_rdy) begin
        out_val  <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end

  // Set and clear never hit the same bank on one edge: the writer only
  // completes into a bank that was empty when its frame started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     full <= 2'b00;
    else if (en) full <= (full & ~full_clr) | full_set;
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;

  localparam int DW = 16;
  localparam int N  = 16;
  localparam int L2 = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b1;
  logic          in_val = 1'b0;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic          out_rdy = 1'b1;
  logic          out_val;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic          out_last;
  logic          ovf;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_xfer   = 0;

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_val   (in_val),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_rdy  (out_rdy),
    .out_val  (out_val),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_last (out_last),
    .ovf      (ovf)
  );

  // Every presented sample must match the head of the scoreboard; it is
  // popped on the cycle the handshake completes.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_val === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_output: got re=%h im=%h last=%b, expected no output", out_re, out_im, out_last);
      end else if (out_re !== sb[0].re || out_im !== sb[0].im || out_last !== sb[0].last) begin
        $display("FAIL out_data: got re=%h im=%h last=%b, expected re=%h im=%h last=%b",
                 out_re, out_im, out_last, sb[0].re, sb[0].im, sb[0].last);
      end else begin
        n_pass++;
      end
      if (en && out_rdy) begin
        n_xfer++;
        if (sb.size() != 0) e = sb.pop_front();
      end
    end
  end

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < L2; b++) if (k[b]) r |= 1 << (L2 - 1 - b);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one bit-reversed frame (sample i carries re=base+i, im=-(base+i)).
  task automatic feed_frame(input int base, input bit keep);
    if (keep) begin
      for (int k = 0; k < N; k++) begin
        exp_t e;
        int   idx;
        idx    = brev(k);
        e.re   = DW'(base + idx);
        e.im   = DW'(-(base + idx));
        e.last = (k == N - 1);
        sb.push_back(e);
      end
    end
    for (int i = 0; i < N; i++) begin
      in_val = 1'b1;
      in_re  = DW'(base + i);
      in_im  = DW'(-(base + i));
      tick();
    end
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while (sb.size() != 0 && c < maxc) begin
      tick();
      c++;
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL drain_timeout: %0d samples still pending, expected 0", sb.size());
    else n_pass++;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if (out_val !== 1'b0) $display("FAIL idle_after_drain: out_val=%b, expected 0", out_val);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset();
    in_val = 1'b0; en = 1'b1; out_rdy = 1'b1;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (out_val !== 1'b0) $display("FAIL reset_out_val: got %b, expected 0", out_val); else n_pass++;
    n_checks++; if (out_re !== '0) $display("FAIL reset_out_re: got %h, expected 0", out_re); else n_pass++;
    n_checks++; if (out_im !== '0) $display("FAIL reset_out_im: got %h, expected 0", out_im); else n_pass++;
    n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b, expected 0", out_last); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b, expected 0", ovf); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    out_rdy = 1'b1;
    feed_frame(0, 1'b1);
    in_val = 1'b0;
    @(negedge clk);
    n_checks++; if (out_val !== 1'b0) $display("FAIL latency_early: out_val=%b, expected 0", out_val); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_val !== 1'b1) $display("FAIL latency_first: out_val=%b, expected 1", out_val); else n_pass++;
    drain(60);
    n_checks++; if (ovf !== 1'b0) $display("FAIL single_ovf: got %b, expected 0", ovf); else n_pass++;
  endtask

  task automatic test_back_to_back();
    out_rdy = 1'b1;
    fork
      begin
        feed_frame(100, 1'b1);
        feed_frame(200, 1'b1);
        feed_frame(300, 1'b1);
        in_val = 1'b0;
      end
      begin
        int w = 0;
        int run = 0;
        while (out_val !== 1'b1 && w < 100) begin @(negedge clk); w++; end
        while (out_val === 1'b1 && run < 60) begin run++; @(negedge clk); end
        n_checks++;
        if (run != 3 * N) $display("FAIL b2b_contiguous: %0d valid cycles in a row, expected %0d", run, 3 * N);
        else n_pass++;
      end
    join
    tick();
    drain(40);
  endtask

  task automatic test_ready_toggle();
    int start;
    start = n_xfer;
    out_rdy = 1'b1;
    fork
      begin feed_frame(50, 1'b1); in_val = 1'b0; end
      begin
        repeat (N + 1) tick();
        for (int c = 0; c < 50; c++) begin out_rdy = ~out_rdy; tick(); end
        out_rdy = 1'b1;
      end
    join
    drain(60);
    n_checks++;
    if (n_xfer - start != N) $display("FAIL toggle_count: %0d transfers, expected %0d", n_xfer - start, N);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int start;
    start = n_xfer;
    out_rdy = 1'b0;
    feed_frame(400, 1'b1);
    feed_frame(500, 1'b1);
    feed_frame(600, 1'b0);  // both banks held full -> this frame is dropped
    in_val = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    n_checks++; if (ovf !== 1'b1) $display("FAIL ovf_set: got %b, expected 1", ovf); else n_pass++;
    n_checks++; if (out_val !== 1'b1) $display("FAIL ovf_stalled_val: got %b, expected 1", out_val); else n_pass++;
    tick();
    out_rdy = 1'b1;
    drain(80);
    n_checks++;
    if (n_xfer - start != 2 * N) $display("FAIL ovf_count: %0d transfers, expected %0d", n_xfer - start, 2 * N);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    out_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_val = 1'b1; in_re = DW'(700 + i); in_im = DW'(-(700 + i));
      tick();
    end
    in_re = DW'(707); in_im = DW'(-707);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_val !== 1'b0 || out_re !== '0 || out_im !== '0 || out_last !== 1'b0 || ovf !== 1'b0)
      $display("FAIL midreset_outputs: val=%b re=%h im=%h last=%b ovf=%b, expected all 0",
               out_val, out_re, out_im, out_last, ovf);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0; in_val = 1'b0;
    tick();
    feed_frame(800, 1'b1);
    in_val = 1'b0;
    drain(60);
  endtask

  task automatic test_enable_stall();
    logic [DW-1:0] exp_re;
    out_rdy = 1'b1;
    feed_frame(900, 1'b1);
    in_val = 1'b0;
    repeat (4) tick();
    en = 1'b0; in_val = 1'b1; in_re = 16'hdead; in_im = 16'hbeef;
    exp_re = DW'(900 + brev(3));  // bins 0..2 have gone; bin 3 is on the bus
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_val !== 1'b1 || out_re !== exp_re)
        $display("FAIL en_stall_hold: val=%b re=%h, expected val=1 re=%h", out_val, out_re, exp_re);
      else n_pass++;
    end
    tick();
    en = 1'b1; in_val = 1'b0;
    drain(60);
    feed_frame(950, 1'b1);
    in_val = 1'b0;
    drain(60);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ready_toggle();
    test_overflow();
    test_reset_midframe();
    test_enable_stall();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
